// File: rtl/mem_credit_responder_pkg.sv
// Shared types and constants for the responder end of the credit-based
// memory network. Buffer depth must match the initiator's credit count.
package mem_credit_responder_pkg;

  localparam int MAXMEMCREDIT    = 64;
  localparam int MAXMEMCREDITMSB = $clog2(MAXMEMCREDIT);   // count spans 0..MAXMEMCREDIT
  localparam int MEMCREDIT_DW    = 64;
  localparam int MEMCREDIT_PTR_W = $clog2(MAXMEMCREDIT);

  typedef bit   [MAXMEMCREDITMSB:0]  mem_credit_cnt_type;
  typedef logic [MEMCREDIT_DW-1:0]   mem_credit_req_type;

endpackage

// File: rtl/mem_credit_fifo.sv
// Dual-pointer request buffer with registered count and a combinational
// head read, so a write into an empty buffer is visible one cycle later.
module mem_credit_fifo
  import mem_credit_responder_pkg::*;
#(
  parameter int DEPTH = MAXMEMCREDIT,
  parameter int DW    = MEMCREDIT_DW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [DW-1:0]      wr_data,
  input  logic               rd_en,
  output logic [DW-1:0]      rd_data,
  output mem_credit_cnt_type count,
  output logic               full,
  output logic               empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DW-1:0]    mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign empty = (count == '0);
  assign full  = (count == mem_credit_cnt_type'(DEPTH));
  assign do_rd = rd_en && !empty;
  // A full buffer still accepts a write when the head leaves the same cycle.
  assign do_wr = wr_en && (!full || do_rd);

  // Head is forced to zero when empty so stale storage never leaks out.
  assign rd_data = empty ? '0 : mem[rd_ptr];

  // Storage write port.
  // NOTE: storage is deliberately not reset; pointers and count define
  // validity, and leaving the array out of reset lets it map to RAM.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally modulo DEPTH; count tracks net occupancy.
  // NOTE: non-blocking assignments keep every register sampling the
  // pre-edge values, so ordering inside the block does not matter.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_rd) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + mem_credit_cnt_type'(1);
        2'b01:   count <= count - mem_credit_cnt_type'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_credit_responder.sv
// Memory-controller end of the credit network: buffers requests, hands them
// to the controller over valid/ready and returns one credit per dequeue.
// Define MEMCREDIT_BATCH_EN to batch credit returns (CREDIT_BATCH per strobe,
// partial batches flushed after BATCH_TIMEOUT idle cycles).
module mem_credit_responder
  import mem_credit_responder_pkg::*;
#(
  parameter int DEPTH = MAXMEMCREDIT,
  parameter int DW    = MEMCREDIT_DW
`ifdef MEMCREDIT_BATCH_EN
  ,
  parameter int CREDIT_BATCH  = 4,
  parameter int BATCH_TIMEOUT = 16
`endif
) (
  input  logic               gclk,
  input  logic               rst,
  input  logic               req_valid,
  input  logic [DW-1:0]      req_data,
  output logic               out_valid,
  output logic [DW-1:0]      out_data,
  input  logic               out_ready,
  output logic               credit_ret,
  output logic               credit_ret_valid,
  output mem_credit_cnt_type credit_ret_cnt,
  output mem_credit_cnt_type occupancy,
  output logic               overflow_err
);

  logic full;
  logic empty;
  logic deq;

  mem_credit_fifo #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_fifo (
    .clk     (gclk),
    .rst     (rst),
    .wr_en   (req_valid),
    .wr_data (req_data),
    .rd_en   (out_ready),
    .rd_data (out_data),
    .count   (occupancy),
    .full    (full),
    .empty   (empty)
  );

  assign out_valid = !empty;
  assign deq       = out_valid && out_ready;

  // Sticky flag: the initiator sent a request it had no credit for.
  always_ff @(posedge gclk) begin
    if (rst)                           overflow_err <= 1'b0;
    else if (req_valid && full && !deq) overflow_err <= 1'b1;
  end

`ifdef MEMCREDIT_BATCH_EN

  localparam int IDLE_W = $clog2(BATCH_TIMEOUT);

  mem_credit_cnt_type pending;
  mem_credit_cnt_type pending_inc;
  logic [IDLE_W-1:0]  idle_cnt;
  logic               flush;

  // Pending includes the current dequeue so a full batch returns immediately.
  assign pending_inc = pending + mem_credit_cnt_type'(deq);
  assign flush = (pending_inc >= mem_credit_cnt_type'(CREDIT_BATCH)) ||
                 (!deq && (pending != '0) && (idle_cnt == IDLE_W'(BATCH_TIMEOUT - 1)));

  assign credit_ret = 1'b0;

  // Accumulate dequeues and emit a strobe on a full batch or idle timeout.
  always_ff @(posedge gclk) begin
    if (rst) begin
      pending          <= '0;
      idle_cnt         <= '0;
      credit_ret_valid <= 1'b0;
      credit_ret_cnt   <= '0;
    end else begin
      credit_ret_valid <= 1'b0;
      credit_ret_cnt   <= '0;
      if (flush) begin
        credit_ret_valid <= 1'b1;
        credit_ret_cnt   <= pending_inc;
        pending          <= '0;
        idle_cnt         <= '0;
      end else begin
        pending <= pending_inc;
        if (deq)                 idle_cnt <= '0;
        else if (pending != '0)  idle_cnt <= idle_cnt + IDLE_W'(1);
      end
    end
  end

`else

  assign credit_ret_valid = 1'b0;
  assign credit_ret_cnt   = '0;

  // One credit pulse in the cycle after each accepted dequeue.
  always_ff @(posedge gclk) begin
    if (rst) credit_ret <= 1'b0;
    else     credit_ret <= deq;
  end

`endif

endmodule

// File: tb/tb_mem_credit_responder.sv
// Scoreboard bench for mem_credit_responder: a queue model of the buffer
// predicts head data, occupancy, overflow and credit behaviour every cycle.
module tb_mem_credit_responder;
  import mem_credit_responder_pkg::*;

  localparam int DEPTH = MAXMEMCREDIT;
  localparam int DW    = MEMCREDIT_DW;

  logic               gclk = 1'b0;
  logic               rst;
  logic               req_valid;
  logic [DW-1:0]      req_data;
  logic               out_valid;
  logic [DW-1:0]      out_data;
  logic               out_ready;
  logic               credit_ret;
  logic               credit_ret_valid;
  mem_credit_cnt_type credit_ret_cnt;
  mem_credit_cnt_type occupancy;
  logic               overflow_err;

  mem_credit_responder dut (
    .gclk             (gclk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_data         (req_data),
    .out_valid        (out_valid),
    .out_data         (out_data),
    .out_ready        (out_ready),
    .credit_ret       (credit_ret),
    .credit_ret_valid (credit_ret_valid),
    .credit_ret_cnt   (credit_ret_cnt),
    .occupancy        (occupancy),
    .overflow_err     (overflow_err)
  );

  always #5 gclk = ~gclk;

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [DW-1:0] sb[$];
  int            m_cnt = 0;
  bit            m_ovf = 1'b0;
  int            credits_seen = 0;
  int            strobes[$];

  task automatic drive(input bit v, input logic [DW-1:0] d, input bit r);
    req_valid = v;
    req_data  = d;
    out_ready = r;
  endtask

  // One clock: check head before the edge, advance the model, check after.
  task automatic tick();
    bit deq_m;
    bit enq_ok;
    bit exp_cr;
    deq_m  = 1'b0;
    enq_ok = 1'b0;
    if (!rst) begin
      deq_m = (m_cnt > 0) && out_ready;
      n_tests++;
      if (out_valid !== (m_cnt > 0)) begin
        n_fail++;
        $display("FAIL out_valid: got %b expected %b", out_valid, (m_cnt > 0));
      end
      if (deq_m) begin
        n_tests++;
        if (out_data !== sb[0]) begin
          n_fail++;
          $display("FAIL out_data: got %h expected %h", out_data, sb[0]);
        end
        void'(sb.pop_front());
      end
      enq_ok = req_valid && ((m_cnt < DEPTH) || deq_m);
      if (enq_ok) sb.push_back(req_data);
      if (req_valid && !enq_ok) m_ovf = 1'b1;
      m_cnt = m_cnt + int'(enq_ok) - int'(deq_m);
    end else begin
      sb.delete();
      m_cnt = 0;
      m_ovf = 1'b0;
    end
    @(posedge gclk);
    #1;
`ifdef MEMCREDIT_BATCH_EN
    exp_cr = 1'b0;
`else
    exp_cr = deq_m;
`endif
    n_tests++;
    if (occupancy !== mem_credit_cnt_type'(m_cnt)) begin
      n_fail++;
      $display("FAIL occupancy: got %0d expected %0d", occupancy, m_cnt);
    end
    n_tests++;
    if (overflow_err !== m_ovf) begin
      n_fail++;
      $display("FAIL overflow_err: got %b expected %b", overflow_err, m_ovf);
    end
    n_tests++;
    if (credit_ret !== exp_cr) begin
      n_fail++;
      $display("FAIL credit_ret: got %b expected %b", credit_ret, exp_cr);
    end
    if (credit_ret === 1'b1) credits_seen++;
    if (credit_ret_valid === 1'b1) begin
      credits_seen += int'(credit_ret_cnt);
      strobes.push_back(int'(credit_ret_cnt));
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    drive(1'b0, '0, 1'b0);
    tick();
    rst = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    n_tests++;
    if ({out_valid, out_data, credit_ret, credit_ret_valid, credit_ret_cnt,
         occupancy, overflow_err} !== '0) begin
      n_fail++;
      $display("FAIL %s: outputs not zero (valid %b data %h cr %b crv %b crc %0d occ %0d ovf %b), expected all 0",
               name, out_valid, out_data, credit_ret, credit_ret_valid, credit_ret_cnt,
               occupancy, overflow_err);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, '0, 1'b0);
    tick();
    tick();
    check_all_zero("reset_outputs");
    rst = 1'b0;
  endtask

  task automatic test_single();
    drive(1'b1, 64'hA5, 1'b1);
    tick();
    n_tests++;
    if (out_valid !== 1'b1 || out_data !== 64'hA5 || occupancy !== 7'd1) begin
      n_fail++;
      $display("FAIL single_fallthrough: got valid %b data %h occ %0d expected 1 a5 1",
               out_valid, out_data, occupancy);
    end
    drive(1'b0, '0, 1'b1);
    tick();
    n_tests++;
    if (out_valid !== 1'b0 || occupancy !== 7'd0) begin
      n_fail++;
      $display("FAIL single_drain: got valid %b occ %0d expected 0 0", out_valid, occupancy);
    end
`ifndef MEMCREDIT_BATCH_EN
    n_tests++;
    if (credit_ret !== 1'b1) begin
      n_fail++;
      $display("FAIL single_credit: got %b expected 1", credit_ret);
    end
`endif
    drive(1'b0, '0, 1'b0);
    tick();
  endtask

  task automatic fill(input int n, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, base | DW'(i), 1'b0);
      tick();
    end
    drive(1'b0, '0, 1'b0);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, '0, 1'b1);
      tick();
    end
    drive(1'b0, '0, 1'b0);
  endtask

  task automatic test_back_to_back();
    int c0;
    c0 = credits_seen;
    fill(DEPTH, 64'hC0DE_0000_0000_0000);
    n_tests++;
    if (occupancy !== 7'd64 || overflow_err !== 1'b0 || credits_seen != c0) begin
      n_fail++;
      $display("FAIL fill_full: got occ %0d ovf %b credits %0d expected 64 0 0",
               occupancy, overflow_err, credits_seen - c0);
    end
    drain(DEPTH);
    n_tests++;
    if (occupancy !== 7'd0) begin
      n_fail++;
      $display("FAIL drain_empty: got occ %0d expected 0", occupancy);
    end
`ifndef MEMCREDIT_BATCH_EN
    n_tests++;
    if (credits_seen - c0 != DEPTH) begin
      n_fail++;
      $display("FAIL drain_credits: got %0d expected %0d", credits_seen - c0, DEPTH);
    end
`endif
  endtask

  task automatic test_overflow();
    fill(DEPTH, 64'h1111_0000_0000_0000);
    drive(1'b1, 64'hDEAD, 1'b0);
    tick();
    n_tests++;
    if (overflow_err !== 1'b1 || occupancy !== 7'd64) begin
      n_fail++;
      $display("FAIL overflow_drop: got ovf %b occ %0d expected 1 64", overflow_err, occupancy);
    end
    drain(DEPTH);
    n_tests++;
    if (overflow_err !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_sticky: got %b expected 1", overflow_err);
    end
    pulse_reset();
    fill(DEPTH, 64'h2222_0000_0000_0000);
    drive(1'b1, 64'hBEEF, 1'b1);
    tick();
    n_tests++;
    if (overflow_err !== 1'b0 || occupancy !== 7'd64) begin
      n_fail++;
      $display("FAIL full_simul: got ovf %b occ %0d expected 0 64", overflow_err, occupancy);
    end
    drain(DEPTH);
  endtask

  task automatic test_reset_mid();
    int c0;
    fill(40, 64'h3333_0000_0000_0000);
    rst = 1'b1;
    drive(1'b0, '0, 1'b1);
    tick();
    check_all_zero("reset_mid_outputs");
    rst = 1'b0;
    c0 = credits_seen;
    drive(1'b0, '0, 1'b1);
    for (int i = 0; i < 3; i++) tick();
    n_tests++;
    if (credits_seen != c0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_idle: got credits %0d valid %b expected 0 0",
               credits_seen - c0, out_valid);
    end
    drive(1'b1, 64'h77, 1'b0);
    tick();
    n_tests++;
    if (out_valid !== 1'b1 || out_data !== 64'h77) begin
      n_fail++;
      $display("FAIL reset_mid_latency: got valid %b data %h expected 1 77", out_valid, out_data);
    end
    drain(1);
  endtask

  task automatic test_wrap();
    int c0;
    fill(3, 64'h4444_0000_0000_0000);
    c0 = credits_seen;
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, 64'h5555_0000_0000_0000 | DW'(i * 7 + 1), 1'b1);
      tick();
    end
    n_tests++;
    if (occupancy !== 7'd3) begin
      n_fail++;
      $display("FAIL wrap_occ: got %0d expected 3", occupancy);
    end
`ifndef MEMCREDIT_BATCH_EN
    n_tests++;
    if (credits_seen - c0 != 100) begin
      n_fail++;
      $display("FAIL wrap_credits: got %0d expected 100", credits_seen - c0);
    end
`endif
    drain(3);
  endtask

`ifdef MEMCREDIT_BATCH_EN
  task automatic test_batch();
    int c0;
    pulse_reset();
    strobes.delete();
    c0 = credits_seen;
    fill(6, 64'h6666_0000_0000_0000);
    drain(6);
    n_tests++;
    if (strobes.size() != 1 || strobes[0] != 4) begin
      n_fail++;
      $display("FAIL batch_full: got %0d strobes first %0d expected 1 strobe of 4",
               strobes.size(), (strobes.size() > 0) ? strobes[0] : -1);
    end
    for (int i = 0; i < 15; i++) tick();
    n_tests++;
    if (strobes.size() != 1) begin
      n_fail++;
      $display("FAIL batch_early: got %0d strobes expected 1", strobes.size());
    end
    tick();
    n_tests++;
    if (strobes.size() != 2 || strobes[1] != 2 || credits_seen - c0 != 6) begin
      n_fail++;
      $display("FAIL batch_timeout: got %0d strobes last %0d sum %0d expected 2 2 6",
               strobes.size(), (strobes.size() > 1) ? strobes[1] : -1, credits_seen - c0);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    drive(1'b0, '0, 1'b0);
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
    test_wrap();
`ifdef MEMCREDIT_BATCH_EN
    test_batch();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_credit_responder.md
Name: mem_credit_responder

Overview:
- Responder (memory-controller) end of the credit-based memory network.
- Initiator resets its credit counter to MAXMEMCREDIT and spends one credit per request.
- This block buffers up to MAXMEMCREDIT requests, presents them to the memory controller via valid/ready, and returns one credit per dequeued entry.
- Sits between the pipeline memory-network egress and each memory controller port (one instance per port, NMEMCTRLPORT total).

Parameters:
- DEPTH, MAXMEMCREDIT (64), buffer entries; must equal the initiator's credit count; power of two.
- DW, 64, request payload width in bits.
- CREDIT_BATCH, 4, credits accumulated before a batched return (MEMCREDIT_BATCH_EN only).
- BATCH_TIMEOUT, 16, idle cycles after which a partial batch is flushed (MEMCREDIT_BATCH_EN only).

Ports:
- gclk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  request present this cycle (no ready: credit-guaranteed).
- req_data  in  DW  request payload.
- out_valid  out  1  head entry valid toward memory controller.
- out_data  out  DW  head entry payload.
- out_ready  in  1  memory controller accepts head entry.
- credit_ret  out  1  one credit returned this cycle (macro absent).
- credit_ret_valid  out  1  batched credit return strobe (macro present).
- credit_ret_cnt  out  MAXMEMCREDITMSB+1  credits in batched return (macro present).
- occupancy  out  MAXMEMCREDITMSB+1  current entry count, 0..DEPTH.
- overflow_err  out  1  sticky protocol-violation flag.

Behaviour:
- Reset (rst high at gclk edge):
  - All outputs are 0.
  - Pointers and count are cleared; buffered entries are discarded.
  - No credits are returned for flushed entries, because the initiator resets its counter too.
  - Reset mid-operation behaves identically.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is MAXMEMCREDITMSB+1 bits and never exceeds DEPTH.
- Enqueue: req_valid at edge N writes req_data at the tail. If the buffer was empty, out_valid rises at N+1 with out_data equal to that payload (1-cycle fall-through).
- Dequeue: occurs on an edge where out_valid && out_ready. out_data and out_valid hold stable while out_valid && !out_ready.
- Simultaneous enqueue and dequeue: count unchanged. This is legal at full, since the freed slot is reused in the same cycle.
- Enqueue with count==DEPTH and no same-cycle dequeue:
  - Request dropped.
  - overflow_err set; stays set until rst.
  - Count unchanged, no credit generated.
- Empty: out_valid=0; out_ready is ignored.
- Credit (macro absent): credit_ret=1 in cycle N+1 for each dequeue at edge N. Exactly one credit per accepted dequeue.
- occupancy is registered and reflects count after edge N.

Optional Feature:
- Macro: MEMCREDIT_BATCH_EN.
- Absent: credit_ret per-dequeue pulse as above; credit_ret_valid/credit_ret_cnt tied 0.
- Present: credit_ret tied 0.
  - A pending counter accumulates dequeues.
  - When pending (including the current dequeue) reaches CREDIT_BATCH, credit_ret_valid=1 next cycle with credit_ret_cnt=pending; pending then clears to 0, or to 1 if a dequeue coincides with the return.
  - An idle counter increments each cycle with pending>0 and no dequeue, and resets on dequeue. At BATCH_TIMEOUT it flushes the partial batch the same way.
  - Total credits returned always equals total dequeues.
  - rst clears pending and the idle counter.

Decomposition:
- Shared package (alongside the global config): mem_credit_cnt_type = bit [MAXMEMCREDITMSB:0]; DEPTH-derived pointer width constant; mem_credit_req_type payload typedef.
- One sub-module, mem_credit_fifo:
  - Dual-pointer storage plus count, full/empty.
  - BRAM when BRAMPROT/SPRBRAM select it, else LUTram.
- The top-level module holds credit return, batching and error logic.

Test Plan:
- Reset, then one req_valid with req_data=0xA5 and out_ready=1 → out_valid at cycle+1 with out_data=0xA5; credit_ret pulse at cycle+2; occupancy 1 then 0.
- 64 back-to-back requests with out_ready=0 → occupancy=64, overflow_err=0, no credits; then out_ready=1 for 64 cycles → 64 credit_ret pulses, in-order data, occupancy 0.
- Full (64), then req_valid with out_ready=0 → payload dropped, overflow_err=1 sticky, occupancy stays 64; a second case with out_ready=1 in the same cycle → accepted, no error.
- 40 entries buffered, rst asserted one cycle → all outputs 0, no credit pulses; a new request afterwards appears with 1-cycle latency.
- Pointer wrap: 100 enqueue/dequeue pairs at occupancy ~3 → FIFO order preserved across wrap; credits total 100.
- With MEMCREDIT_BATCH_EN, CREDIT_BATCH=4, BATCH_TIMEOUT=16:
  - 6 dequeues → credit_ret_cnt=4 strobe.
  - After 16 idle cycles → credit_ret_cnt=2 strobe.
  - Sum is 6.
